// File: rtl/lsm_address_sequencer.sv
// Address sequencer for load/store-multiple transfers.
// Walks a captured register list and emits register number and address per step.
module lsm_address_sequencer #(
  parameter int WORD_BYTES = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        STEP,
  input  logic [31:0] IR,
  input  logic [31:0] RN_VALUE,
  output logic        BUSY,
  output logic        VALID,
  output logic [3:0]  REG_NUM,
  output logic [31:0] MEM_ADDR,
  output logic        LAST,
  output logic [4:0]  REG_COUNT,
  output logic [31:0] WB_VALUE,
  output logic        DONE
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ACTIVE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [31:0] W = 32'(WORD_BYTES);

  state_t      state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [31:0] addr_q, addr_d;
  logic        p_q, p_d;
  logic        u_q, u_d;
  logic [31:0] base_q, base_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] wb_q, wb_d;

  logic [4:0]  pop;
  logic [3:0]  low_idx;
  logic [31:0] span;
  logic        one_left;

  // Popcount and lowest set bit of the remaining list.
  always_comb begin
    pop     = 5'd0;
    low_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      pop = pop + 5'(list_q[i]);
    end
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) low_idx = 4'(i);
    end
    span     = W * {27'd0, pop};
    one_left = (list_q != 16'd0) &&
               ((list_q & (list_q - 16'd1)) == 16'd0);
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      p_q     <= 1'b0;
      u_q     <= 1'b0;
      base_q  <= '0;
      count_q <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      p_q     <= p_d;
      u_q     <= u_d;
      base_q  <= base_d;
      count_q <= count_d;
      wb_q    <= wb_d;
    end
  end

  // Next-state logic: capture, address setup, then walk the list.
  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    p_d     = p_q;
    u_d     = u_q;
    base_d  = base_q;
    count_d = count_q;
    wb_d    = wb_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          list_d  = IR[15:0];
          p_d     = IR[24];
          u_d     = IR[23];
          base_d  = RN_VALUE;
          state_d = LOAD;
        end
      end
      LOAD: begin
        count_d = pop;
        if (u_q) begin
          wb_d   = base_q + span;
          addr_d = base_q + (p_q ? W : 32'd0);
        end else begin
          wb_d   = base_q - span;
          addr_d = base_q - span + (p_q ? 32'd0 : W);
        end
        if (pop == 5'd0) begin
          wb_d    = base_q;
          addr_d  = addr_q;
          state_d = FINISH;
        end else begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (STEP) begin
          list_d = list_q & ~(16'd1 << low_idx);
          if (one_left) state_d = FINISH;
          else          addr_d  = addr_q + W;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign BUSY      = (state_q == LOAD) || (state_q == ACTIVE);
  assign VALID     = (state_q == ACTIVE);
  assign REG_NUM   = VALID ? low_idx : 4'd0;
  assign MEM_ADDR  = addr_q;
  assign LAST      = VALID && one_left;
  assign REG_COUNT = count_q;
  assign WB_VALUE  = wb_q;
  assign DONE      = (state_q == FINISH);

endmodule

// File: tb/tb_lsm_address_sequencer.sv
// Bench for lsm_address_sequencer: directed plan cases plus random
// sequences checked against an arithmetic transfer model.
module tb_lsm_address_sequencer;

  localparam int WB = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        STEP = 1'b0;
  logic [31:0] IR = '0;
  logic [31:0] RN_VALUE = '0;
  logic        BUSY, VALID, LAST, DONE;
  logic [3:0]  REG_NUM;
  logic [31:0] MEM_ADDR, WB_VALUE;
  logic [4:0]  REG_COUNT;

  int checks = 0;
  int errors = 0;

  lsm_address_sequencer #(.WORD_BYTES(WB)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .STEP(STEP),
    .IR(IR), .RN_VALUE(RN_VALUE), .BUSY(BUSY), .VALID(VALID),
    .REG_NUM(REG_NUM), .MEM_ADDR(MEM_ADDR), .LAST(LAST),
    .REG_COUNT(REG_COUNT), .WB_VALUE(WB_VALUE), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Transfer model: N registers occupy N consecutive words; the lowest
  // word address depends on the addressing mode, registers ascend with it.
  function automatic void model(input logic p, input logic u,
                                input logic [15:0] l,
                                input logic [31:0] rn,
                                output int n,
                                output logic [31:0] lo,
                                output logic [31:0] wb);
    n = 0;
    for (int i = 0; i < 16; i++) if (l[i]) n++;
    if (u) begin
      lo = rn + (p ? 32'(WB) : 32'd0);
      wb = rn + 32'(WB * n);
    end else begin
      lo = rn - 32'(WB * n) + (p ? 32'd0 : 32'(WB));
      wb = rn - 32'(WB * n);
    end
    if (n == 0) wb = rn;
  endfunction

  function automatic int kth_bit(input logic [15:0] l, input int k);
    int c;
    c = 0;
    kth_bit = -1;
    for (int i = 0; i < 16; i++) begin
      if (l[i]) begin
        if (c == k) kth_bit = i;
        c++;
      end
    end
  endfunction

  function automatic logic [31:0] mk_ir(input logic p, input logic u,
                                        input logic [15:0] l);
    logic [31:0] r;
    r = $urandom;
    r[24] = p;
    r[23] = u;
    r[15:0] = l;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #3;
    checks++;
    if ({BUSY, VALID, REG_NUM, MEM_ADDR, LAST, REG_COUNT, WB_VALUE, DONE} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b addr=%h wb=%h done=%b, want all 0", BUSY, VALID, MEM_ADDR, WB_VALUE, DONE);
    end
    tick();
    tick();
    RESET = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b valid=%b done=%b, want 0", BUSY, VALID, DONE);
    end
  endtask

  task automatic test_directed();
    logic        tp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic        tu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [15:0] tl [4] = '{16'h000F, 16'h8001, 16'h0003, 16'h0006};
    logic [31:0] tr [4] = '{32'h1000, 32'h2000, 32'hFFFFFFFC, 32'h200};
    logic [31:0] tw [4] = '{32'h1010, 32'h1FF8, 32'h4, 32'h1F8};
    logic [31:0] ta [4] = '{32'h1000, 32'h1FF8, 32'hFFFFFFFC, 32'h1FC};
    int n;
    logic [31:0] lo, wb, ea;
    for (int c = 0; c < 4; c++) begin
      model(tp[c], tu[c], tl[c], tr[c], n, lo, wb);
      IR = mk_ir(tp[c], tu[c], tl[c]);
      RN_VALUE = tr[c];
      START = 1'b1;
      tick();
      START = 1'b0;
      checks++;
      if (BUSY !== 1'b1 || VALID !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_load: got busy=%b valid=%b, want 1 0", c, BUSY, VALID);
      end
      tick();
      checks++;
      if (MEM_ADDR !== ta[c] || WB_VALUE !== tw[c]) begin
        errors++;
        $display("FAIL dir%0d_first: got addr=%h wb=%h, want %h %h", c, MEM_ADDR, WB_VALUE, ta[c], tw[c]);
      end
      for (int k = 0; k < n; k++) begin
        ea = lo + 32'(WB * k);
        checks++;
        if (VALID !== 1'b1 || REG_NUM !== 4'(kth_bit(tl[c], k)) ||
            MEM_ADDR !== ea || LAST !== (k == n - 1) ||
            REG_COUNT !== 5'(n) || WB_VALUE !== wb) begin
          errors++;
          $display("FAIL dir%0d_xfer%0d: got v=%b reg=%0d addr=%h last=%b cnt=%0d wb=%h, want 1 %0d %h %b %0d %h", c, k, VALID, REG_NUM, MEM_ADDR, LAST, REG_COUNT, WB_VALUE, kth_bit(tl[c], k), ea, k == n - 1, n, wb);
        end
        STEP = 1'b1;
        tick();
        STEP = 1'b0;
      end
      checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b0 || VALID !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_done: got done=%b busy=%b valid=%b, want 1 0 0", c, DONE, BUSY, VALID);
      end
      tick();
      checks++;
      if (DONE !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_done_pulse: got done=%b, want 0", c, DONE);
      end
    end
  endtask

  task automatic test_empty();
    IR = mk_ir(1'($urandom), 1'($urandom), 16'h0000);
    RN_VALUE = 32'h40;
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++;
    if (VALID !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL empty_load: got valid=%b done=%b, want 0 0", VALID, DONE);
    end
    tick();
    checks++;
    if (DONE !== 1'b1 || VALID !== 1'b0 || REG_COUNT !== 5'd0 || WB_VALUE !== 32'h40) begin
      errors++;
      $display("FAIL empty_done: got done=%b valid=%b cnt=%0d wb=%h, want 1 0 0 00000040", DONE, VALID, REG_COUNT, WB_VALUE);
    end
    tick();
    checks++;
    if (DONE !== 1'b0 || VALID !== 1'b0) begin
      errors++;
      $display("FAIL empty_after: got done=%b valid=%b, want 0 0", DONE, VALID);
    end
  endtask

  task automatic test_stall();
    IR = mk_ir(1'b1, 1'b1, 16'h0120);
    RN_VALUE = 32'h100;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (VALID !== 1'b1 || REG_NUM !== 4'd5 || MEM_ADDR !== 32'h104 || LAST !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got v=%b reg=%0d addr=%h last=%b, want 1 5 00000104 0", i, VALID, REG_NUM, MEM_ADDR, LAST);
      end
      START = (i == 2);
      RN_VALUE = 32'hDEAD0000;
      tick();
    end
    START = 1'b0;
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    checks++;
    if (REG_NUM !== 4'd8 || MEM_ADDR !== 32'h108 || LAST !== 1'b1 ||
        WB_VALUE !== 32'h108 || REG_COUNT !== 5'd2) begin
      errors++;
      $display("FAIL stall_second: got reg=%0d addr=%h last=%b wb=%h cnt=%0d, want 8 00000108 1 00000108 2", REG_NUM, MEM_ADDR, LAST, WB_VALUE, REG_COUNT);
    end
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    checks++;
    if (DONE !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got done=%b, want 1", DONE);
    end
    tick();
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle: got busy=%b done=%b, want 0 0", BUSY, DONE);
    end
  endtask

  task automatic test_reset_mid();
    IR = mk_ir(1'b0, 1'b1, 16'h000F);
    RN_VALUE = 32'h1000;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    checks++;
    if (REG_NUM !== 4'd1 || MEM_ADDR !== 32'h1004) begin
      errors++;
      $display("FAIL rmid_second: got reg=%0d addr=%h, want 1 00001004", REG_NUM, MEM_ADDR);
    end
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if ({BUSY, VALID, REG_NUM, MEM_ADDR, LAST, REG_COUNT, WB_VALUE, DONE} !== '0) begin
      errors++;
      $display("FAIL rmid_async: got busy=%b valid=%b reg=%0d addr=%h cnt=%0d wb=%h, want all 0", BUSY, VALID, REG_NUM, MEM_ADDR, REG_COUNT, WB_VALUE);
    end
    tick();
    RESET = 1'b0;
    IR = mk_ir(1'b0, 1'b0, 16'h0006);
    RN_VALUE = 32'h200;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    checks++;
    if (REG_NUM !== 4'd1 || MEM_ADDR !== 32'h1FC || WB_VALUE !== 32'h1F8 || VALID !== 1'b1) begin
      errors++;
      $display("FAIL rmid_da1: got v=%b reg=%0d addr=%h wb=%h, want 1 1 000001fc 000001f8", VALID, REG_NUM, MEM_ADDR, WB_VALUE);
    end
    STEP = 1'b1;
    tick();
    checks++;
    if (REG_NUM !== 4'd2 || MEM_ADDR !== 32'h200 || LAST !== 1'b1) begin
      errors++;
      $display("FAIL rmid_da2: got reg=%0d addr=%h last=%b, want 2 00000200 1", REG_NUM, MEM_ADDR, LAST);
    end
    tick();
    STEP = 1'b0;
    checks++;
    if (DONE !== 1'b1) begin
      errors++;
      $display("FAIL rmid_done: got done=%b, want 1", DONE);
    end
    tick();
  endtask

  task automatic test_random();
    logic p, u;
    logic [15:0] l;
    logic [31:0] rn, lo, wb, ea;
    int n, k, cyc;
    logic st;
    for (int s = 0; s < 40; s++) begin
      p = 1'($urandom);
      u = 1'($urandom);
      l = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      rn = $urandom;
      model(p, u, l, rn, n, lo, wb);
      IR = mk_ir(p, u, l);
      RN_VALUE = rn;
      START = 1'b1;
      tick();
      START = 1'b0;
      checks++;
      if (BUSY !== 1'b1 || VALID !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_load: got busy=%b valid=%b, want 1 0", s, BUSY, VALID);
      end
      tick();
      k = 0;
      cyc = 0;
      while (k < n && cyc < 400) begin
        ea = lo + 32'(WB * k);
        checks++;
        if (VALID !== 1'b1 || REG_NUM !== 4'(kth_bit(l, k)) ||
            MEM_ADDR !== ea || LAST !== (k == n - 1) ||
            REG_COUNT !== 5'(n) || WB_VALUE !== wb || DONE !== 1'b0) begin
          errors++;
          $display("FAIL rnd%0d_xfer%0d: got v=%b reg=%0d addr=%h last=%b cnt=%0d wb=%h, want 1 %0d %h %b %0d %h", s, k, VALID, REG_NUM, MEM_ADDR, LAST, REG_COUNT, WB_VALUE, kth_bit(l, k), ea, k == n - 1, n, wb);
        end
        st = ($urandom_range(0, 2) != 0);
        STEP = st;
        START = ($urandom_range(0, 7) == 0);
        tick();
        STEP = 1'b0;
        START = 1'b0;
        if (st) k++;
        cyc++;
      end
      if (k < n) begin
        checks++;
        errors++;
        $display("FAIL rnd%0d_timeout: got %0d transfers, want %0d", s, k, n);
      end
      checks++;
      if (DONE !== 1'b1 || VALID !== 1'b0 || BUSY !== 1'b0 ||
          REG_COUNT !== 5'(n) || WB_VALUE !== wb) begin
        errors++;
        $display("FAIL rnd%0d_done: got done=%b v=%b busy=%b cnt=%0d wb=%h, want 1 0 0 %0d %h", s, DONE, VALID, BUSY, REG_COUNT, WB_VALUE, n, wb);
      end
      START = 1'($urandom);
      STEP = 1'($urandom);
      tick();
      START = 1'b0;
      STEP = 1'b0;
      checks++;
      if (BUSY !== 1'b0 || DONE !== 1'b0 || VALID !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_idle: got busy=%b done=%b valid=%b, want 0 0 0", s, BUSY, DONE, VALID);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_empty();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
